if_stage_pp: RTL and testbench
==============================

# if_stage_pp

Parametrised instruction-fetch stage for the RISC-V pipeline. Holds the PC, fetches from a combinational instruction ROM, and selects the next PC. It adds three things over the fixed 32-bit fetch stage:

- configurable width, ROM depth and reset vector;
- address-fault detection;
- an optional direct-mapped branch target buffer (BTB) for taken-branch prediction.

It sits in front of the IF/ID register and takes redirects from the branch/jump resolution logic.

## Interface
- XLEN, 32, PC and instruction width
- ROM_AW, 6, ROM word-address bits (depth 2^ROM_AW words)
- RESET_PC, 0, PC value loaded on reset
- BTB_IW, 2, BTB index bits (2^BTB_IW entries)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- IFWrite  in  1  1 = advance PC, 0 = hold (stall)
- Redirect  in  1  resolved Jump|Branch from later stage
- RedirectAddr  in  XLEN  redirect target
- UpdateEn  in  1  BTB update strobe
- UpdatePC  in  XLEN  PC of the resolved branch
- UpdateTarget  in  XLEN  resolved target
- UpdateTaken  in  1  branch resolved taken
- PC  out  XLEN  current fetch PC
- Instruction_if  out  XLEN  fetched instruction
- PredTaken_if  out  1  BTB predicted taken for PC
- IF_flush  out  1  equals Redirect (combinational)
- AddrFault  out  1  current PC misaligned or outside ROM

## Operation
- **Next-PC priority:**
  1. reset → RESET_PC
  2. Redirect → RedirectAddr. Redirect overrides a stall; it is never lost when IFWrite=0.
  3. !IFWrite → hold PC
  4. PredTaken_if → BTB target
  5. otherwise PC+4, modulo 2^XLEN (wraps silently)
- **Fetch:** Instruction_if = ROM[PC[ROM_AW+1:2]] when AddrFault=0. When AddrFault=1, output 32'h00000013 (NOP).
- **AddrFault:** 1 when PC[1:0]≠0 or PC[XLEN-1:ROM_AW+2]≠0.
  - A misaligned RedirectAddr is still loaded.
  - The fault persists until the next redirect or reset.
  - PC+4 is still computed from a faulted PC.
- **BTB index and tag:** index = PC[BTB_IW+1:2]; tag = PC[XLEN-1:BTB_IW+2].
- **BTB lookup:** combinational. A hit requires valid & tag match.
- **BTB update (on the clock edge when UpdateEn=1):**
  - UpdateTaken=1: write {valid=1, tag(UpdatePC), UpdateTarget}, replacing any existing entry.
  - UpdateTaken=0: clear valid, only when the stored tag matches.

## Timing
- **Reset values:** PC=RESET_PC, all BTB valid bits=0, PredTaken_if=0.
  - Instruction_if = ROM[RESET_PC], or NOP if RESET_PC is faulting.
  - IF_flush follows Redirect even during reset.
- **Latency:**
  - PC changes one edge after a redirect or advance.
  - Instruction_if, AddrFault and PredTaken_if are combinational from PC in the same cycle.
- **Update and lookup to the same index in the same cycle:** the lookup sees the old contents; the new entry is visible from the next cycle.
- **Reset coinciding with UpdateEn:** reset wins; the BTB is cleared.
- **Redirect coinciding with a BTB hit:** Redirect wins.
- **Stall with a BTB hit:** PC holds and PredTaken_if stays asserted.

## Configuration
- IF_BTB_EN defined: BTB storage and prediction are compiled in.
- IF_BTB_EN undefined:
  - no BTB storage;
  - PredTaken_if tied 0;
  - UpdateEn, UpdatePC, UpdateTarget and UpdateTaken are ignored;
  - next PC is chosen from reset, Redirect, stall and PC+4 only.

## Structure
- Shared package `if_pkg`:
  - NOP constant 32'h00000013;
  - BTB entry typedef {valid, tag, target};
  - next-PC select enum {SEL_RESET, SEL_REDIRECT, SEL_HOLD, SEL_PRED, SEL_SEQ}.
- One sub-module `branch_target_buffer` (lookup plus update port), instantiated only under IF_BTB_EN.
- InstructionROM and the PC+4 adder are reused unchanged.

## Test plan
- Reset with RESET_PC=0, IFWrite=1 for 4 cycles → PC=0,4,8,12; Instruction_if matches ROM words 0–3.
- IFWrite=0 at PC=8 for 3 cycles → PC holds 8; then Redirect=1, RedirectAddr=0x40 with IFWrite=0 → PC=0x40 next cycle, IF_flush=1 during that cycle.
- Redirect to 0x102 → AddrFault=1, Instruction_if=0x00000013. Redirect to 0x400 with ROM_AW=6 → AddrFault=1. Redirect to 0x10 → AddrFault clears.
- (IF_BTB_EN) UpdateEn with UpdatePC=0x8, UpdateTarget=0x30, UpdateTaken=1, then fetch reaches 0x8 → PredTaken_if=1, next PC=0x30. Then update with UpdateTaken=0 → the next visit to 0x8 goes to 0xC.
- (IF_BTB_EN) Alias: UpdatePC=0x8 taken, then fetch 0x18 (same index for BTB_IW=2, different tag) → no hit, PC=0x1C. Reset asserted alongside an update → all entries invalid.
- PC=0xFFFFFFFC with XLEN=32, IFWrite=1 → PC wraps to 0x00000000.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the parametrised fetch stage:
//                NOP encoding, BTB entry layout, next-PC select encoding and
//                the contents of the instruction ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // addi x0, x0, 0: substituted for any fetch from a faulting PC
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    // Geometry the pipeline ships with; the BTB builds the same entry layout
    // at its own parameterised widths when these are overridden.
    localparam int c_XLEN       = 32;
    localparam int c_BTB_IW     = 2;
    localparam int c_BTB_TAG_W  = c_XLEN - c_BTB_IW - 2;

    typedef struct packed {
        logic                   valid;
        logic [c_BTB_TAG_W-1:0] tag;
        logic [c_XLEN-1:0]      target;
    } btb_entry_t;

    // Next-PC source, listed in priority order
    typedef enum logic [2:0] {
        SEL_RESET    = 3'd0,
        SEL_REDIRECT = 3'd1,
        SEL_HOLD     = 3'd2,
        SEL_PRED     = 3'd3,
        SEL_SEQ      = 3'd4
    } next_sel_e;

    // Instruction ROM image: word i holds "addi x1, x0, i", so every word is
    // distinct and self-identifying.
    function automatic logic [31:0] rom_word(input logic [11:0] idx);
        return {idx, 20'h0_0093};
    endfunction

endpackage : if_pkg
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Direct-mapped branch target buffer. Combinational lookup on
//                the fetch PC; one synchronous update port from the branch
//                resolution logic. Taken updates allocate/replace, not-taken
//                updates invalidate only an entry whose tag matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int XLEN   = 32,
    parameter int BTB_IW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [XLEN-1:0] target,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken
);

    localparam int c_TAG_W = XLEN - BTB_IW - 2;
    localparam int c_DEPTH = 1 << BTB_IW;

    typedef struct packed {
        logic               valid;
        logic [c_TAG_W-1:0] tag;
        logic [XLEN-1:0]    target;
    } entry_t;

    entry_t              r_mem [c_DEPTH];

    logic [BTB_IW-1:0]   w_lk_idx;
    logic [c_TAG_W-1:0]  w_lk_tag;
    logic [BTB_IW-1:0]   w_up_idx;
    logic [c_TAG_W-1:0]  w_up_tag;
    logic                w_unused_align;

    assign w_lk_idx = lookup_pc[BTB_IW+1:2];
    assign w_lk_tag = lookup_pc[XLEN-1:BTB_IW+2];
    assign w_up_idx = update_pc[BTB_IW+1:2];
    assign w_up_tag = update_pc[XLEN-1:BTB_IW+2];

    // Byte-offset bits never reach the index or tag
    assign w_unused_align = ^{lookup_pc[1:0], update_pc[1:0]};

    // Lookup reads the pre-edge contents, so a same-cycle update is seen next cycle
    assign hit    = r_mem[w_lk_idx].valid && (r_mem[w_lk_idx].tag == w_lk_tag);
    assign target = r_mem[w_lk_idx].target;

    // Entry storage: reset clears every valid bit and takes priority over an update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (update_en) begin
            if (update_taken) begin
                r_mem[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: update_target};
            end else if (r_mem[w_up_idx].tag == w_up_tag) begin
                r_mem[w_up_idx].valid <= 1'b0;
            end
        end
    end

endmodule : branch_target_buffer
`default_nettype wire

// File: rtl/if_stage_pp.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pp
//  Description : Parametrised instruction-fetch stage. Holds the PC, reads a
//                combinational instruction ROM, flags misaligned or
//                out-of-ROM PCs and selects the next PC from reset, redirect,
//                stall, BTB prediction or PC+4.
//                Build option IF_BTB_EN compiles in the branch target buffer;
//                without it PredTaken_if is 0 and the update port is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage_pp
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ROM_AW   = 6,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              BTB_IW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IFWrite,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectAddr,
    input  logic            UpdateEn,
    input  logic [XLEN-1:0] UpdatePC,
    input  logic [XLEN-1:0] UpdateTarget,
    input  logic            UpdateTaken,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Instruction_if,
    output logic            PredTaken_if,
    output logic            IF_flush,
    output logic            AddrFault
);

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   w_pc_seq;
    logic [XLEN-1:0]   w_pred_target;
    logic              w_pred;
    logic              w_fault;
    logic [ROM_AW-1:0] w_rom_idx;
    logic [31:0]       w_rom_word;
    next_sel_e         w_sel;

    // ---------------- instruction ROM and fault detection ------------------
    assign w_rom_idx  = r_pc[ROM_AW+1:2];
    assign w_rom_word = rom_word(12'(w_rom_idx));

    // Misaligned, or any address bit above the ROM window set
    assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc[XLEN-1:ROM_AW+2] != '0);

    assign Instruction_if = w_fault ? XLEN'(c_NOP) : XLEN'(w_rom_word);
    assign AddrFault      = w_fault;
    assign IF_flush       = Redirect;
    assign PC             = r_pc;

    // Sequential successor; a faulted PC still advances and wraps at 2^XLEN
    assign w_pc_seq = r_pc + XLEN'(4);

    // ---------------- optional branch prediction ---------------------------
`ifdef IF_BTB_EN
    branch_target_buffer #(
        .XLEN   (XLEN),
        .BTB_IW (BTB_IW)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (r_pc),
        .hit           (w_pred),
        .target        (w_pred_target),
        .update_en     (UpdateEn),
        .update_pc     (UpdatePC),
        .update_target (UpdateTarget),
        .update_taken  (UpdateTaken)
    );
`else
    logic w_unused_update;

    assign w_pred          = 1'b0;
    assign w_pred_target   = '0;
    assign w_unused_update = ^{UpdateEn, UpdatePC, UpdateTarget, UpdateTaken};
`endif

    assign PredTaken_if = w_pred;

    // Next-PC source in priority order; Redirect beats a stall so it is never lost
    always_comb begin
        w_sel = SEL_SEQ;
        if (reset) begin
            w_sel = SEL_RESET;
        end else if (Redirect) begin
            w_sel = SEL_REDIRECT;
        end else if (!IFWrite) begin
            w_sel = SEL_HOLD;
        end else if (w_pred) begin
            w_sel = SEL_PRED;
        end
    end

    // Next-PC mux driven by the selected source
    always_comb begin
        w_pc_next = w_pc_seq;
        case (w_sel)
            SEL_RESET:    w_pc_next = RESET_PC;
            SEL_REDIRECT: w_pc_next = RedirectAddr;
            SEL_HOLD:     w_pc_next = r_pc;
            SEL_PRED:     w_pc_next = w_pred_target;
            default:      w_pc_next = w_pc_seq;
        endcase
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

endmodule : if_stage_pp
`default_nettype wire

// File: tb/tb_if_stage_pp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage_pp
//  Description : Self-checking bench for if_stage_pp (default geometry:
//                XLEN=32, ROM_AW=6, RESET_PC=0, BTB_IW=2). The expected next
//                PC is queued when a cycle's stimulus is applied and popped
//                after the edge, where PC, Instruction_if and AddrFault are
//                compared. BTB scenarios are built when IF_BTB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage_pp;

    localparam logic [31:0] c_EXP_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFWrite;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic        UpdateEn;
    logic [31:0] UpdatePC;
    logic [31:0] UpdateTarget;
    logic        UpdateTaken;
    logic [31:0] PC;
    logic [31:0] Instruction_if;
    logic        PredTaken_if;
    logic        IF_flush;
    logic        AddrFault;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    if_stage_pp #(
        .XLEN     (32),
        .ROM_AW   (6),
        .RESET_PC (32'h0),
        .BTB_IW   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Redirect       (Redirect),
        .RedirectAddr   (RedirectAddr),
        .UpdateEn       (UpdateEn),
        .UpdatePC       (UpdatePC),
        .UpdateTarget   (UpdateTarget),
        .UpdateTaken    (UpdateTaken),
        .PC             (PC),
        .Instruction_if (Instruction_if),
        .PredTaken_if   (PredTaken_if),
        .IF_flush       (IF_flush),
        .AddrFault      (AddrFault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference fault rule: misaligned or above the 256-byte ROM window
    function automatic logic exp_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc[31:8] != 24'h0);
    endfunction

    // Reference ROM image: word i is addi x1, x0, i
    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [31:0] idx;
        if (exp_fault(pc)) return c_EXP_NOP;
        idx = (pc >> 2) & 32'h3F;
        return (idx << 20) | 32'h0000_0093;
    endfunction

    // Pop the expected PC for this cycle and compare the fetch outputs
    task automatic check_pc(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".pc"},    PC,               e);
            check({tag, ".instr"}, Instruction_if,   exp_instr(e));
            check({tag, ".fault"}, 32'(AddrFault),   32'(exp_fault(e)));
        end
    endtask

    task automatic set_upd(input logic en, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic tk);
        UpdateEn     = en;
        UpdatePC     = pc;
        UpdateTarget = tgt;
        UpdateTaken  = tk;
    endtask

    // One cycle: apply stimulus, check combinational outputs, queue next PC
    task automatic tick(input string tag, input logic ifw, input logic redir,
                        input logic [31:0] raddr, input logic exp_pred,
                        input logic [31:0] exp_next);
        IFWrite      = ifw;
        Redirect     = redir;
        RedirectAddr = raddr;
        #1;
        check({tag, ".flush"}, 32'(IF_flush),     32'(redir));
        check({tag, ".pred"},  32'(PredTaken_if), 32'(exp_pred));
        exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
        UpdateEn = 1'b0;
        Redirect = 1'b0;
        check_pc(tag);
    endtask

    // Reset cycle with a pending redirect; flush must still follow Redirect
    task automatic do_reset(input string tag);
        reset        = 1'b1;
        Redirect     = 1'b1;
        RedirectAddr = 32'h40;
        IFWrite      = 1'b1;
        #1;
        check({tag, ".flush"}, 32'(IF_flush), 32'd1);
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        Redirect = 1'b0;
        UpdateEn = 1'b0;
        check_pc(tag);
        check({tag, ".pred"}, 32'(PredTaken_if), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        IFWrite = 1'b0;
        Redirect = 1'b0;
        RedirectAddr = 32'h0;
        set_upd(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        do_reset("reset");

        // Sequential fetch, stall, redirect over stall
        tick("seq0", 1'b1, 1'b0, 32'h0, 1'b0, 32'h4);
        tick("seq1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick("hold", 1'b0, 1'b0, 32'h0, 1'b0, 32'h8);
        end
        tick("redir_stall", 1'b0, 1'b1, 32'h40, 1'b0, 32'h40);
        tick("seq40",       1'b1, 1'b0, 32'h0,  1'b0, 32'h44);

        // Address faults
        tick("misalign",    1'b1, 1'b1, 32'h102, 1'b0, 32'h102);
        tick("misalign_pp", 1'b1, 1'b0, 32'h0,   1'b0, 32'h106);
        tick("out_of_rom",  1'b1, 1'b1, 32'h400, 1'b0, 32'h400);
        tick("fault_clear", 1'b1, 1'b1, 32'h10,  1'b0, 32'h10);

        // Wrap at 2^32
        tick("top",  1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
        tick("wrap", 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);

`ifdef IF_BTB_EN
        // Allocate 0x8 -> 0x30, predict, stall on a hit
        set_upd(1'b1, 32'h8, 32'h30, 1'b1);
        tick("b_upd",   1'b1, 1'b0, 32'h0, 1'b0, 32'h4);
        tick("b_4",     1'b1, 1'b0, 32'h0, 1'b0, 32'h8);
        tick("b_stall", 1'b0, 1'b0, 32'h0, 1'b1, 32'h8);
        tick("b_hit",   1'b1, 1'b0, 32'h0, 1'b1, 32'h30);
        // Redirect beats a hit
        tick("b_to8",   1'b1, 1'b1, 32'h8,  1'b0, 32'h8);
        tick("b_rwin",  1'b1, 1'b1, 32'h20, 1'b1, 32'h20);
        // Not-taken update with a different tag leaves the entry alone
        set_upd(1'b1, 32'h18, 32'h0, 1'b0);
        tick("b_nclr",  1'b1, 1'b1, 32'h8, 1'b0, 32'h8);
        tick("b_keep",  1'b1, 1'b0, 32'h0, 1'b1, 32'h30);
        // Matching not-taken update invalidates
        set_upd(1'b1, 32'h8, 32'h0, 1'b0);
        tick("b_clr",   1'b1, 1'b1, 32'h8, 1'b0, 32'h8);
        tick("b_miss",  1'b1, 1'b0, 32'h0, 1'b0, 32'hC);
        // Alias: 0x18 shares index with 0x8 but not the tag
        set_upd(1'b1, 32'h8, 32'h30, 1'b1);
        tick("b_alias_upd", 1'b1, 1'b1, 32'h18, 1'b0, 32'h18);
        tick("b_alias",     1'b1, 1'b0, 32'h0,  1'b0, 32'h1C);
        // Same-cycle update and lookup: old contents seen first
        set_upd(1'b1, 32'h1C, 32'h50, 1'b1);
        tick("b_same", 1'b1, 1'b1, 32'h1C, 1'b0, 32'h1C);
        tick("b_new",  1'b1, 1'b0, 32'h0,  1'b1, 32'h50);
        // Reset alongside an update clears everything
        set_upd(1'b1, 32'h50, 32'h60, 1'b1);
        do_reset("b_reset");
        tick("r_0",   1'b1, 1'b0, 32'h0,  1'b0, 32'h4);
        tick("r_4",   1'b1, 1'b0, 32'h0,  1'b0, 32'h8);
        tick("r_8",   1'b1, 1'b0, 32'h0,  1'b0, 32'hC);
        tick("r_1c",  1'b1, 1'b1, 32'h1C, 1'b0, 32'h1C);
        tick("r_1c_seq", 1'b1, 1'b0, 32'h0, 1'b0, 32'h20);
        tick("r_50",  1'b1, 1'b1, 32'h50, 1'b0, 32'h50);
        tick("r_50_seq", 1'b1, 1'b0, 32'h0, 1'b0, 32'h54);
`else
        // Update port has no effect without the BTB
        set_upd(1'b1, 32'h8, 32'h30, 1'b1);
        tick("nb_upd", 1'b1, 1'b0, 32'h0, 1'b0, 32'h4);
        tick("nb_4",   1'b1, 1'b0, 32'h0, 1'b0, 32'h8);
        tick("nb_8",   1'b1, 1'b0, 32'h0, 1'b0, 32'hC);
`endif

        if (exp_q.size() != 0) begin
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_stage_pp
`default_nettype wire
